// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared maze types: headings, reverse helper, picker FSM states
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_FALLBACK = 2'd2,
    ST_DONE     = 2'd3
  } picker_state_t;

  function automatic dir_t reverse_dir(input dir_t d);
    logic [1:0] r;
    r = 2'(d + 2'd2);
    return dir_t'(r);
  endfunction

endpackage

// File: rtl/ghost_dir_picker.sv
// rtl/ghost_dir_picker.sv - frightened-ghost heading picker driven by an LFSR nibble
// Optional macro GHOST_DIR_RETRY_EN: resample live random nibble before the deterministic scan.
module ghost_dir_picker
  import pacman_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_random,
  input  logic       i_req,
  input  logic [3:0] i_legal,
  input  logic [1:0] i_cur_dir,
  output logic [1:0] o_dir,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_none
);

  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 5);
`ifdef GHOST_DIR_RETRY_EN
  localparam int unsigned CHECK_LIMIT = MAX_RETRY + 4;
`else
  localparam int unsigned CHECK_LIMIT = 4;
`endif
  localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(CHECK_LIMIT - 1);

  picker_state_t    state_q, state_d;
  logic [3:0]       legal_q, legal_d;
  dir_t             cur_q, cur_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             none_q, none_d;

  dir_t rev_dir;
  logic accept;
  logic unused_rnd;

  assign unused_rnd = i_random[3];
  assign rev_dir    = reverse_dir(cur_q);
  assign accept     = legal_q[cand_q] && (cand_q != rev_dir);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      legal_q <= 4'd0;
      cur_q   <= DIR_UP;
      cand_q  <= 2'd0;
      step_q  <= 2'd0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      legal_q <= legal_d;
      cur_q   <= cur_d;
      cand_q  <= cand_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      none_q  <= none_d;
    end
  end

  always_comb begin
    state_d = state_q;
    legal_d = legal_q;
    cur_d   = cur_q;
    cand_d  = cand_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    none_d  = none_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          legal_d = i_legal;
          cur_d   = dir_t'(i_cur_dir);
          cand_d  = i_random[1:0];
          // step of -1 is +3 in 2-bit wrap arithmetic
          step_d  = i_random[2] ? 2'd3 : 2'd1;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          dir_d   = dir_t'(cand_q);
          state_d = ST_DONE;
        end else begin
`ifdef GHOST_DIR_RETRY_EN
          if (cnt_q < CNT_W'(MAX_RETRY)) cand_d = i_random[1:0];
          else                           cand_d = 2'(cand_q + step_q);
`else
          cand_d = 2'(cand_q + step_q);
`endif
          cnt_d = 2'(0) + CNT_W'(cnt_q + 1'b1);
          if (cnt_q == LAST_CHECK) state_d = ST_FALLBACK;
        end
      end
      ST_FALLBACK: begin
        if (legal_q[rev_dir]) begin
          dir_d = rev_dir;
        end else begin
          dir_d  = cur_q;
          none_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        none_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state_q == ST_DONE);
    o_busy  = (state_q != ST_IDLE);
    o_dir   = dir_q;
    o_none  = none_q;
  end

endmodule

// File: tb/tb_ghost_dir_picker.sv
// tb/tb_ghost_dir_picker.sv - scoreboard bench for ghost_dir_picker (default build)
module tb_ghost_dir_picker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rnd = 4'd0;
  logic       req = 1'b0;
  logic [3:0] legal = 4'd0;
  logic [1:0] cur = 2'd0;
  logic [1:0] o_dir;
  logic       o_valid, o_busy, o_none;

  ghost_dir_picker dut (
    .i_clk(clk), .i_rst(rst), .i_random(rnd), .i_req(req),
    .i_legal(legal), .i_cur_dir(cur),
    .o_dir(o_dir), .o_valid(o_valid), .o_busy(o_busy), .o_none(o_none)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dir;
    int none;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_dir = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: walk candidates from the nibble, skipping illegal moves and the reverse.
  task automatic model(input int lg, input int cd, input int r,
                       output int dir, output int none, output int lat);
    int rev, step, c;
    rev  = (cd + 2) % 4;
    step = r[2] ? 3 : 1;
    c    = r % 4;
    for (int i = 0; i < 4; i++) begin
      if (lg[c] && c != rev) begin
        dir = c; none = 0; lat = i + 1;
        return;
      end
      c = (c + step) % 4;
    end
    lat = 5;
    if (lg[rev]) begin dir = rev; none = 0; end
    else         begin dir = cd;  none = 1; end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dir", int'(o_dir), e.dir);
          chk("none", int'(o_none), e.none);
          chk("latency_edge", cyc, e.edge_n);
          last_dir = e.dir;
        end
      end else begin
        chk("none_idle", int'(o_none), 0);
        chk("dir_held", int'(o_dir), last_dir);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 20) begin @(negedge clk); n++; end
    if (o_busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("valid_timeout", int'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [3:0] lg, input logic [1:0] cd, input logic [3:0] r,
                       input bit extra);
    int d, nn, lat;
    exp_t e;
    wait_idle();
    model(int'(lg), int'(cd), int'(r), d, nn, lat);
    e.dir = d; e.none = nn; e.edge_n = cyc + 1 + lat;
    exp_q.push_back(e);
    legal = lg; cur = cd; rnd = r; req = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", int'(o_busy), 1);
    req = 1'b0;
    legal = 4'($urandom); cur = 2'($urandom); rnd = 4'($urandom);
    if (extra) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #1;
    chk("rst_dir", int'(o_dir), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_none", int'(o_none), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(4'b1111, 2'd0, 4'b0001, 1'b0);
    issue(4'b0101, 2'd2, 4'b0010, 1'b0);
    issue(4'b0001, 2'd0, 4'b0110, 1'b0);
    issue(4'b0100, 2'd0, 4'b0011, 1'b0);
    issue(4'b0000, 2'd3, 4'b0101, 1'b0);
    issue(4'b1111, 2'd1, 4'b1000, 1'b1);
    issue(4'b0010, 2'd3, 4'b0100, 1'b1);

    // Reset while the third candidate is being evaluated.
    wait_idle();
    legal = 4'b0000; cur = 2'd3; rnd = 4'b0000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_dir", int'(o_dir), 0);
    chk("abort_valid", int'(o_valid), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_none", int'(o_none), 0);
    @(negedge clk);
    rst = 1'b0;
    last_dir = 0;
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    issue(4'b1011, 2'd1, 4'b0111, 1'b0);

    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_dir_picker.md
# ghost_dir_picker

Picks a ghost's next heading at a maze intersection while the ghost is frightened. It sits directly downstream of the 16-bit LFSR random source, consuming its 4-bit `o_random_out` nibble. On each tile-centre request it uses that nibble to choose a random legal, non-reversing direction. It returns the choice to the ghost movement controller through a one-cycle valid pulse.

## Interface
- `MAX_RETRY`, default 3: number of fresh-random resamples before the deterministic scan. Used only when `GHOST_DIR_RETRY_EN` is defined. Range 1..7.
- `i_clk`  input  1  system clock.
- `i_rst`  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `i_random`  input  4  random nibble from the LFSR. Bits [1:0] give the candidate direction; bit [2] gives the scan step sense. Bit [3] is unused.
- `i_req`  input  1  single-cycle request at a tile centre.
- `i_legal`  input  4  legal-move mask, indexed by direction.
- `i_cur_dir`  input  2  ghost's current heading.
- `o_dir`  output  2  chosen direction, valid when `o_valid` is high and held until the next result.
- `o_valid`  output  1  one-cycle pulse marking a new `o_dir`.
- `o_busy`  output  1  high from request acceptance until the `o_valid` cycle inclusive.
- `o_none`  output  1  high with `o_valid` when no legal direction existed.

## Operation
- Direction encoding: 0 = up, 1 = left, 2 = down, 3 = right.
- Reverse of `d` is `(d+2) mod 4`; 2-bit wrap-around arithmetic throughout.
- FSM states: IDLE, CHECK, FALLBACK, DONE.
- IDLE: when `i_req` = 1, register `i_legal`, `i_cur_dir`, candidate `cand = i_random[1:0]`, `step = i_random[2] ? -1 : +1`, and clear the check counter. Go to CHECK.
- CHECK, one candidate per cycle. The candidate is accepted when `legal[cand]` = 1 and `cand != reverse(cur_dir)`.
  - On accept: `o_dir <= cand`, go to DONE.
  - Otherwise: `cand <= cand + step`, counter increments.
  - After 4 failed checks, go to FALLBACK.
- FALLBACK:
  - If `legal[reverse(cur_dir)]` = 1: `o_dir <= reverse(cur_dir)`.
  - Otherwise: `o_dir <= cur_dir` and `o_none <= 1`.
  - Then go to DONE.
- DONE: `o_valid` = 1 for exactly one cycle, then return to IDLE. `o_none` clears along with `o_valid`.
- `i_req` while `o_busy` = 1 is ignored, not queued.
- `i_legal`, `i_cur_dir` and `i_random` changes after acceptance have no effect, except on the live-sample path under the macro.

## Timing
- Reset values: `o_dir` = 0, `o_valid` = 0, `o_busy` = 0, `o_none` = 0, state IDLE.
- Reset mid-operation aborts immediately with no `o_valid`.
- Request accepted at edge T. `o_busy` is high from T.
- A candidate accepted on check k (k = 0..3) evaluates in the cycle after edge T+k. `o_dir` updates at edge T+k+1, and `o_valid` is high during the cycle following that edge.
- Fallback: `o_valid` follows edge T+5.
- Minimum latency is 2 edges from acceptance to the `o_valid` cycle. Maximum is 6 edges without the macro.
- A request in the cycle right after `o_valid` (back to IDLE) is accepted.

## Configuration
- `GHOST_DIR_RETRY_EN` defined:
  - On each of the first `MAX_RETRY` failed checks, the next candidate is the live `i_random[1:0]` instead of `cand + step`.
  - After that, the 4-step deterministic scan runs from the last candidate.
  - Maximum check count is `MAX_RETRY + 4`. Fallback and DONE are unchanged.
- Undefined: deterministic scan only; `MAX_RETRY` is ignored.

## Structure
- Shared package `pacman_pkg` holds:
  - `dir_t` (2-bit enum: `DIR_UP`, `DIR_LEFT`, `DIR_DOWN`, `DIR_RIGHT`);
  - a `reverse_dir` function;
  - the FSM state typedef.
- The LFSR source is instantiated by the parent, not inside this block.
- No sub-module; one file.

## Test plan
- Legal = 4'b1111, cur = up(0), random = 4'b0001 -> check 0 accepts left(1); `o_valid` 2 edges after the req edge; `o_none` = 0.
- Legal = 4'b0101 (up, down), cur = down(2), random = 4'b0010 (cand = down, step +1) -> checks down(legal, accept) -> `o_dir` = 2 after 2 edges.
- Legal = 4'b0001 (only up), cur = up, random = 4'b0110 (cand = down, step −1) -> checks 2, 1 fail, then 0 accepts -> `o_dir` = 0 after 4 edges.
- Legal = 4'b0100 (only down = reverse), cur = up -> 4 failed checks, then FALLBACK -> `o_dir` = 2, `o_none` = 0, `o_valid` 6 edges after the req edge.
- Legal = 4'b0000, cur = right(3) -> `o_dir` = 3, `o_none` = 1 together with `o_valid`; both low the next cycle.
- Second `i_req` while busy is ignored. Asserting `i_rst` at check 2 aborts: no `o_valid`, all outputs 0, and the next request behaves normally.
